// File: rtl/open_list_ctrl_if.sv
// -----------------------------------------------------------------------------
// open_list_ctrl_if
// Request/response bundle between the two open-list requesters and
// open_list_ctrl.
//
// Handshake (valid/ready style):
//   A requester raises req[r] together with valid op/x/y/idx fields for slot r.
//   The controller answers with grant (one-hot), held for the whole operation.
//   The operands are captured one cycle after grant rises; they may change
//   freely after that. done pulses for exactly one cycle with ok/found/index
//   valid, grant still high. The requester drops req on the cycle after done;
//   a req still high when the controller is back in IDLE is a new request.
//
// Signals (slot r occupies bits [W*r +: W] of the packed per-requester fields):
//   req   [1:0]          request per requester
//   op    [3:0]          opcode per requester: 00 INSERT, 01 SEARCH, 10 REMOVE,
//                        11 NOP
//   x, y  [2*COORD_W-1:0] coordinate per requester
//   idx   [2*IDX_W-1:0]  entry index per requester (REMOVE)
//   grant [1:0]          one-hot grant
//   done                 completion pulse
//   ok, found, index     result, valid with done and held until the next done
//   count, full, empty   occupancy status
// -----------------------------------------------------------------------------
interface open_list_ctrl_if #(
    parameter int COORD_W = 8,
    parameter int IDX_W   = 9,
    parameter int CNT_W   = 10
);
    logic [1:0]           req;
    logic [3:0]           op;
    logic [2*COORD_W-1:0] x;
    logic [2*COORD_W-1:0] y;
    logic [2*IDX_W-1:0]   idx;
    logic [1:0]           grant;
    logic                 done;
    logic                 ok;
    logic                 found;
    logic [IDX_W-1:0]     index;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;

    // Requester side
    modport master (
        output req, op, x, y, idx,
        input  grant, done, ok, found, index, count, full, empty
    );

    // Controller side
    modport slave (
        input  req, op, x, y, idx,
        output grant, done, ok, found, index, count, full, empty
    );
endinterface

// File: rtl/open_list_ctrl.sv
// -----------------------------------------------------------------------------
// open_list_ctrl
// Owns the A* open list: X/Y coordinate arrays plus an occupancy counter.
// Two requesters (0 = neighbour expansion, 1 = best-node selector) share it
// through round-robin arbitration. Each grant runs one operation:
//   INSERT  append (x,y) at entry[count]
//   SEARCH  linear scan of entries 0..count-1 for (x,y), one entry per cycle
//   REMOVE  entry[idx] <= entry[count-1], count -= 1
//
// Optional build macro: OPEN_LIST_DUP_CHECK_EN
//   When defined, INSERT first scans the list and refuses to append a
//   coordinate that is already present (ok=0, found=1, index=hit).
//
// Ports:
//   i_clk    in   system clock, rising edge
//   i_rst_n  in   asynchronous active-low reset
//   bus      slave modport of open_list_ctrl_if (request/response bundle)
//   o_state  out  current FSM state (debug)
// -----------------------------------------------------------------------------
module open_list_ctrl #(
    parameter int DEPTH   = 400,
    parameter int COORD_W = 8,
    parameter int IDX_W   = 9,
    parameter int CNT_W   = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    open_list_ctrl_if.slave      bus,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_INSERT = 3'd2,
        S_SCAN   = 3'd3,
        S_REMOVE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] OP_INSERT = 2'b00;
    localparam logic [1:0] OP_SEARCH = 2'b01;
    localparam logic [1:0] OP_REMOVE = 2'b10;

    // Control / result registers
    state_t               r_state;
    logic [1:0]           r_grant;
    logic                 r_done;
    logic                 r_ok;
    logic                 r_found;
    logic [IDX_W-1:0]     r_index;
    logic [CNT_W-1:0]     r_count;
    logic                 r_rr;

    // Operands captured in LATCH
    logic [1:0]           r_op;
    logic [COORD_W-1:0]   r_x;
    logic [COORD_W-1:0]   r_y;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_scan_i;

    // Entry storage; contents are deliberately not reset
    logic [COORD_W-1:0]   r_mem_x [0:DEPTH-1];
    logic [COORD_W-1:0]   r_mem_y [0:DEPTH-1];

    logic [1:0]           w_gnt;
    logic                 w_lsel;
    logic [1:0]           w_op_sel;
    logic [COORD_W-1:0]   w_x_sel;
    logic [COORD_W-1:0]   w_y_sel;
    logic [IDX_W-1:0]     w_idx_sel;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_last;
    logic [IDX_W-1:0]     w_last_idx;
    logic                 w_hit;
    logic                 w_scan_end;
    logic                 w_rm_valid;
    logic                 w_we;
    logic [IDX_W-1:0]     w_waddr;
    logic [COORD_W-1:0]   w_wx;
    logic [COORD_W-1:0]   w_wy;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_last     = r_count - CNT_W'(1);
    assign w_last_idx = w_last[IDX_W-1:0];

    // Scan compare: one entry per cycle at r_scan_i
    assign w_hit      = (r_mem_x[r_scan_i] == r_x) && (r_mem_y[r_scan_i] == r_y);
    assign w_scan_end = (CNT_W'(r_scan_i) == w_last);
    assign w_rm_valid = (CNT_W'(r_idx) < r_count);

    // Arbitration: a lone requester always wins; on a tie the rr pointer picks.
    always_comb begin
        w_gnt = 2'b00;
        case (bus.req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_rr ? 2'b10 : 2'b01;
            default: w_gnt = 2'b00;
        endcase
    end

    // Operand mux keyed on the registered grant (valid during LATCH)
    assign w_lsel    = r_grant[1];
    assign w_op_sel  = w_lsel ? bus.op[3:2] : bus.op[1:0];
    assign w_x_sel   = w_lsel ? bus.x[2*COORD_W-1:COORD_W] : bus.x[COORD_W-1:0];
    assign w_y_sel   = w_lsel ? bus.y[2*COORD_W-1:COORD_W] : bus.y[COORD_W-1:0];
    assign w_idx_sel = w_lsel ? bus.idx[2*IDX_W-1:IDX_W]   : bus.idx[IDX_W-1:0];

    // Single write port: INSERT appends, REMOVE moves the last entry into the hole.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_idx;
        w_wx    = r_x;
        w_wy    = r_y;
        if (r_state == S_INSERT && !w_full) begin
            w_we    = 1'b1;
            w_waddr = IDX_W'(r_count);
        end else if (r_state == S_REMOVE && w_rm_valid) begin
            w_we    = 1'b1;
            w_waddr = r_idx;
            w_wx    = r_mem_x[w_last_idx];
            w_wy    = r_mem_y[w_last_idx];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem_x[w_waddr] <= w_wx;
            r_mem_y[w_waddr] <= w_wy;
        end
    end

    // Main FSM. ok/found/index change only on the edge that raises done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_grant  <= 2'b00;
            r_done   <= 1'b0;
            r_ok     <= 1'b0;
            r_found  <= 1'b0;
            r_index  <= '0;
            r_count  <= '0;
            r_rr     <= 1'b0;
            r_op     <= 2'b00;
            r_x      <= '0;
            r_y      <= '0;
            r_idx    <= '0;
            r_scan_i <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (|bus.req) begin
                        r_grant <= w_gnt;
                        r_rr    <= ~r_rr;
                        r_state <= S_LATCH;
                    end
                end

                S_LATCH: begin
                    r_op     <= w_op_sel;
                    r_x      <= w_x_sel;
                    r_y      <= w_y_sel;
                    r_idx    <= w_idx_sel;
                    r_scan_i <= '0;
                    case (w_op_sel)
                        OP_INSERT: begin
`ifdef OPEN_LIST_DUP_CHECK_EN
                            // Nothing to compare against on an empty list
                            if (r_count == '0) r_state <= S_INSERT;
                            else               r_state <= S_SCAN;
`else
                            r_state <= S_INSERT;
`endif
                        end
                        OP_SEARCH: r_state <= S_SCAN;
                        OP_REMOVE: r_state <= S_REMOVE;
                        default: begin
                            r_ok    <= 1'b0;
                            r_found <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    endcase
                end

                S_INSERT: begin
                    if (w_full) begin
                        r_ok <= 1'b0;
                    end else begin
                        r_ok    <= 1'b1;
                        r_index <= IDX_W'(r_count);
                        r_count <= r_count + CNT_W'(1);
                    end
                    r_found <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end

                S_SCAN: begin
                    if (!w_empty && w_hit) begin
                        // A hit during a duplicate-check INSERT rejects the insert
                        r_found <= 1'b1;
                        r_index <= r_scan_i;
                        r_ok    <= (r_op == OP_SEARCH);
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_empty || w_scan_end) begin
                        if (r_op == OP_SEARCH) begin
                            r_found <= 1'b0;
                            r_ok    <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_INSERT;
                        end
                    end else begin
                        r_scan_i <= r_scan_i + IDX_W'(1);
                    end
                end

                S_REMOVE: begin
                    if (w_rm_valid) begin
                        r_ok    <= 1'b1;
                        r_count <= r_count - CNT_W'(1);
                    end else begin
                        r_ok <= 1'b0;
                    end
                    r_found <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_grant <= 2'b00;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_grant <= 2'b00;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant = r_grant;
    assign bus.done  = r_done;
    assign bus.ok    = r_ok;
    assign bus.found = r_found;
    assign bus.index = r_index;
    assign bus.count = r_count;
    assign bus.full  = w_full;
    assign bus.empty = w_empty;
    assign o_state   = r_state;

endmodule

// File: tb/tb_open_list_ctrl.sv
// -----------------------------------------------------------------------------
// tb_open_list_ctrl
// Directed and randomized stimulus for open_list_ctrl. Expected results come
// from a queue-based model of the open list. Latencies are counted in clock
// cycles from the cycle in which the controller sees the request in IDLE.
// -----------------------------------------------------------------------------
module tb_open_list_ctrl;
    localparam int DEPTH   = 400;
    localparam int COORD_W = 8;
    localparam int IDX_W   = 9;
    localparam int CNT_W   = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    open_list_ctrl_if #(.COORD_W(COORD_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus();
    logic [2:0] dbg_state;

    open_list_ctrl #(.DEPTH(DEPTH), .COORD_W(COORD_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [COORD_W-1:0] mx[$];
    logic [COORD_W-1:0] my[$];
    logic [1:0]         exp_q[$];   // expected grants for back-to-back requests
    logic               m_rr;
    logic               m_ok;
    logic               m_found;
    logic [IDX_W-1:0]   m_index;

    task automatic report();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed=%0d expected=%0d", tag, what, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Applies one operation to the list model and returns expected latency.
    task automatic ref_apply(input logic [1:0] op, input logic [COORD_W-1:0] x,
                             input logic [COORD_W-1:0] y, input int idx,
                             output int lat);
        int n;
        int hit;
        n   = mx.size();
        hit = -1;
        for (int i = 0; i < n; i++) begin
            if (hit < 0 && mx[i] == x && my[i] == y) hit = i;
        end
        lat = 3;
        case (op)
            2'b00: begin
`ifdef OPEN_LIST_DUP_CHECK_EN
                if (hit >= 0) begin
                    lat = hit + 3;
                    m_ok = 1'b0; m_found = 1'b1; m_index = IDX_W'(hit);
                end else begin
                    lat = (n == 0) ? 3 : n + 3;
                    m_found = 1'b0;
                    if (n == DEPTH) m_ok = 1'b0;
                    else begin
                        mx.push_back(x); my.push_back(y);
                        m_ok = 1'b1; m_index = IDX_W'(n);
                    end
                end
`else
                lat = 3;
                m_found = 1'b0;
                if (n == DEPTH) m_ok = 1'b0;
                else begin
                    mx.push_back(x); my.push_back(y);
                    m_ok = 1'b1; m_index = IDX_W'(n);
                end
`endif
            end
            2'b01: begin
                m_ok = 1'b1;
                if (n == 0) begin
                    lat = 3; m_found = 1'b0;
                end else if (hit >= 0) begin
                    lat = hit + 3; m_found = 1'b1; m_index = IDX_W'(hit);
                end else begin
                    lat = n + 2; m_found = 1'b0;
                end
            end
            2'b10: begin
                lat = 3;
                m_found = 1'b0;
                if (idx >= n) m_ok = 1'b0;
                else begin
                    mx[idx] = mx[n-1];
                    my[idx] = my[n-1];
                    void'(mx.pop_back());
                    void'(my.pop_back());
                    m_ok = 1'b1;
                end
            end
            default: begin
                lat = 2; m_ok = 1'b0; m_found = 1'b0;
            end
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mx.delete(); my.delete();
        m_rr = 1'b0; m_ok = 1'b0; m_found = 1'b0; m_index = '0;
    endtask

    // Waits for done under grant exp_g, then checks result, status and release.
    task automatic wait_done(input logic [1:0] exp_g, input int exp_lat,
                             input bit drop, input string tag);
        int lat;
        bit held;
        bit seen;
        lat = 0; held = 1'b1; seen = 1'b0;
        for (int c = 1; c <= 1000 && !seen; c++) begin
            @(negedge clk);
            if (bus.grant !== exp_g) held = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL %s/timeout: observed=no done expected=done within 1000 cycles", tag);
        end
        if (!seen) begin
            report();
        end else begin
            if (drop) bus.req = 2'b00;
            check(tag, "latency", lat, exp_lat);
            check(tag, "grant_held", {31'd0, held}, 32'd1);
            check(tag, "ok", {31'd0, bus.ok}, {31'd0, m_ok});
            check(tag, "found", {31'd0, bus.found}, {31'd0, m_found});
            check(tag, "index", 32'(bus.index), 32'(m_index));
            check(tag, "count", 32'(bus.count), mx.size());
            check(tag, "full", {31'd0, bus.full}, {31'd0, mx.size() == DEPTH});
            check(tag, "empty", {31'd0, bus.empty}, {31'd0, mx.size() == 0});
            @(negedge clk);
            check(tag, "done_pulse", {31'd0, bus.done}, 32'd0);
            check(tag, "grant_release", 32'(bus.grant), 32'd0);
        end
    endtask

    // One operation from a lone requester r; other slot carries junk.
    task automatic do_op(input int r, input logic [1:0] op, input logic [COORD_W-1:0] x,
                         input logic [COORD_W-1:0] y, input int idx, input string tag);
        logic [3:0]           o4;
        logic [2*COORD_W-1:0] x2;
        logic [2*COORD_W-1:0] y2;
        logic [2*IDX_W-1:0]   i2;
        int                   lat;
        @(negedge clk);
        o4 = 4'($urandom);
        x2 = (2*COORD_W)'($urandom);
        y2 = (2*COORD_W)'($urandom);
        i2 = (2*IDX_W)'($urandom);
        o4[2*r +: 2]       = op;
        x2[COORD_W*r +: COORD_W] = x;
        y2[COORD_W*r +: COORD_W] = y;
        i2[IDX_W*r +: IDX_W]     = IDX_W'(idx);
        bus.op  = o4; bus.x = x2; bus.y = y2; bus.idx = i2;
        bus.req = 2'b01 << r;
        m_rr = ~m_rr;
        ref_apply(op, x, y, idx, lat);
        wait_done(2'b01 << r, lat, 1'b1, tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [COORD_W-1:0] cx [2];
        logic [COORD_W-1:0] cy [2];
        int lat;
        int r;
        int n;
        int sel;
        logic [1:0] g;

        rst_n = 1'b0;
        bus.req = 2'b00; bus.op = '0; bus.x = '0; bus.y = '0; bus.idx = '0;
        do_reset();

        // Reset state
        check("reset", "grant", 32'(bus.grant), 32'd0);
        check("reset", "done", {31'd0, bus.done}, 32'd0);
        check("reset", "ok", {31'd0, bus.ok}, 32'd0);
        check("reset", "found", {31'd0, bus.found}, 32'd0);
        check("reset", "index", 32'(bus.index), 32'd0);
        check("reset", "count", 32'(bus.count), 32'd0);
        check("reset", "full", {31'd0, bus.full}, 32'd0);
        check("reset", "empty", {31'd0, bus.empty}, 32'd1);
        check("reset", "state", 32'(dbg_state), 32'd0);

        // Three inserts, third a duplicate
        do_op(0, 2'b00, 8'd5, 8'd7, 0, "ins_a");
        do_op(0, 2'b00, 8'd9, 8'd2, 0, "ins_b");
        do_op(0, 2'b00, 8'd5, 8'd7, 0, "ins_dup");

        // Search hit at the last entry, miss, then empty search
        do_reset();
        do_op(0, 2'b00, 8'd5, 8'd7, 0, "ins_1");
        do_op(1, 2'b00, 8'd9, 8'd2, 0, "ins_2");
        do_op(0, 2'b00, 8'd3, 8'd3, 0, "ins_3");
        do_op(1, 2'b01, 8'd3, 8'd3, 0, "srch_hit");
        do_op(0, 2'b01, 8'd4, 8'd4, 0, "srch_miss");
        do_op(1, 2'b11, 8'd0, 8'd0, 0, "nop");
        do_reset();
        do_op(1, 2'b01, 8'd3, 8'd3, 0, "srch_empty");

        // Remove index 0, then an out-of-range remove
        do_reset();
        do_op(0, 2'b00, 8'd5, 8'd7, 0, "rm_ins1");
        do_op(0, 2'b00, 8'd9, 8'd2, 0, "rm_ins2");
        do_op(0, 2'b00, 8'd3, 8'd3, 0, "rm_ins3");
        do_op(1, 2'b10, 8'd0, 8'd0, 0, "rm_0");
        do_op(0, 2'b01, 8'd3, 8'd3, 0, "rm_moved");
        do_op(1, 2'b10, 8'd0, 8'd0, 5, "rm_oob");
        do_op(0, 2'b01, 8'd5, 8'd7, 0, "rm_gone");

        // Both requesters held high across four operations
        do_reset();
        for (int k = 0; k < 2; k++) begin
            cx[k] = COORD_W'($urandom_range(0, 255));
            cy[k] = COORD_W'($urandom_range(0, 255));
        end
        @(negedge clk);
        bus.op  = 4'b0000;
        bus.x   = {cx[1], cx[0]};
        bus.y   = {cy[1], cy[0]};
        bus.idx = '0;
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            r = m_rr ? 1 : 0;
            exp_q.push_back(2'b01 << r);
            m_rr = ~m_rr;
            ref_apply(2'b00, cx[r], cy[r], 0, lat);
            g = exp_q.pop_front();
            check("rr", "grant_order", 32'(g), (k % 2 == 0) ? 32'd1 : 32'd2);
            wait_done(g, lat, 1'b0, "rr_op");
            cx[r] = COORD_W'($urandom_range(0, 255));
            cy[r] = COORD_W'($urandom_range(0, 255));
            bus.x = {cx[1], cx[0]};
            bus.y = {cy[1], cy[0]};
        end
        bus.req = 2'b00;

        // Randomized mix on a small coordinate space so hits are common
        do_reset();
        for (int k = 0; k < 60; k++) begin
            n   = mx.size();
            sel = $urandom_range(0, 9);
            r   = $urandom_range(0, 1);
            do_op(r, (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11,
                  COORD_W'($urandom_range(0, 3)), COORD_W'($urandom_range(0, 3)),
                  $urandom_range(0, n + 1), "rand");
        end

        // Fill, overflow attempt, then reset in the middle of a scan
        do_reset();
`ifndef OPEN_LIST_DUP_CHECK_EN
        for (int i = 0; i < DEPTH; i++) begin
            do_op(0, 2'b00, COORD_W'(i % 256), COORD_W'(i / 256), 0, "fill");
        end
        check("fill", "full", {31'd0, bus.full}, 32'd1);
        check("fill", "count", 32'(bus.count), 32'd400);
        do_op(1, 2'b00, 8'd200, 8'd200, 0, "ins_full");
`else
        for (int i = 0; i < 20; i++) begin
            do_op(0, 2'b00, COORD_W'(i), 8'd0, 0, "fill");
        end
`endif
        @(negedge clk);
        bus.op = 4'b0001; bus.x = 16'h00FF; bus.y = 16'h00FF; bus.idx = '0;
        bus.req = 2'b01;
        repeat (12) @(negedge clk);
        check("midscan", "grant_before", 32'(bus.grant), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midscan", "grant", 32'(bus.grant), 32'd0);
        check("midscan", "count", 32'(bus.count), 32'd0);
        check("midscan", "empty", {31'd0, bus.empty}, 32'd1);
        check("midscan", "done", {31'd0, bus.done}, 32'd0);
        check("midscan", "state", 32'(dbg_state), 32'd0);
        bus.req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mx.delete(); my.delete();
        m_rr = 1'b0; m_ok = 1'b0; m_found = 1'b0; m_index = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midscan", "no_done", {31'd0, bus.done}, 32'd0);
        end
        do_op(0, 2'b00, 8'd1, 8'd2, 0, "post_reset");

        report();
    end

    // Global time bound
    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: observed=time limit reached expected=bench completion");
        report();
    end

endmodule

// File: doc/open_list_ctrl.md
Name: open_list_ctrl

Overview:
Owns the A* open-list storage: the X/Y coordinate arrays plus an occupancy counter. Two requesters share it through round-robin arbitration: requester 0 is the neighbour-expansion FSM, requester 1 is the best-node selector. It executes one of three sequenced operations per grant:
- INSERT (append)
- SEARCH (linear scan for a coordinate)
- REMOVE (delete by index)

Parameters:
DEPTH, 400, maximum number of open-list entries
COORD_W, 8, width of each X and Y coordinate
IDX_W, 9, entry index width; must satisfy 2^IDX_W >= DEPTH
CNT_W, 10, occupancy count width; must satisfy 2^CNT_W > DEPTH

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
req  in  2  per-requester request, bit r = requester r
op  in  4  per-requester opcode, bits [2r+1:2r]; 00=INSERT, 01=SEARCH, 10=REMOVE, 11=reserved (NOP)
x  in  2*COORD_W  per-requester X coordinate
y  in  2*COORD_W  per-requester Y coordinate
idx  in  2*IDX_W  per-requester index, used by REMOVE
grant  out  2  one-hot; held for the whole operation, including the done cycle
done  out  1  single-cycle completion pulse for the granted requester
ok  out  1  valid with done; 0 = operation rejected
found  out  1  valid with done; SEARCH hit
index  out  IDX_W  valid with done; SEARCH hit index or INSERT write index
count  out  CNT_W  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (asynchronous, Reset_n low):
  - state=IDLE, grant=0, done=0, ok=0, found=0, index=0, count=0, full=0, empty=1, rr pointer=0.
  - Array contents are not reset.
  - Reset asserted mid-operation aborts it; no done pulse is issued and count returns to 0.
- States: IDLE, LATCH, INSERT, SCAN, REMOVE, DONE.
- IDLE:
  - If any req bit is set, grant one requester and go to LATCH.
  - Both requesting: grant the requester indicated by the rr pointer.
  - After every grant, the rr pointer moves to the other requester.
  - A lone requester is always granted.
- LATCH (1 cycle): register op, x, y and idx of the granted requester. Then branch: INSERT, SEARCH to SCAN, REMOVE. A NOP goes to DONE with ok=0.
- INSERT:
  - full: ok=0, no write.
  - Otherwise: write the entry at count, index=count, count+=1, ok=1.
  - Goes to DONE next cycle. Latency from grant to done: 3 cycles.
- SCAN:
  - Compares one entry per cycle, starting at i=0. Only entries 0..count-1 are valid; an entry at i >= count is never compared.
  - Match: found=1, ok=1, index=i, go to DONE.
  - i==count-1 with no match: found=0, ok=1, go to DONE.
  - count==0: DONE on the first SCAN cycle with found=0.
  - Worst-case latency: count+2 cycles to done.
- REMOVE:
  - idx >= count: ok=0, no change.
  - Otherwise: copy entry[count-1] into entry[idx], count-=1, ok=1.
  - Removing the last entry is a self-copy and is legal.
- DONE:
  - done=1 for exactly one cycle; grant is still asserted.
  - Next cycle: grant=0 and state returns to IDLE.
  - The requester must drop req on the cycle after done. A req still high in IDLE is treated as a new request.
- ok, found and index hold their last values until the next done. full and empty are combinational from count.
- Inputs of the non-granted requester are ignored; its req is simply held pending.
- Changing x, y, op or idx after LATCH has no effect.

Optional Feature:
Macro OPEN_LIST_DUP_CHECK_EN.
- Defined:
  - INSERT first runs the SCAN sequence.
  - On a hit: done with ok=0, found=1, index=hit index, no write.
  - On a miss (and not full): append as above with found=0.
  - Latency becomes count+3 cycles.
- Undefined: INSERT appends unconditionally; found is forced to 0 for INSERT.

Test Plan:
- Reset, then INSERT (5,7), (9,2), (5,7) from requester 0 -> three done pulses, index 0,1,2, count=3, ok=1 each. With OPEN_LIST_DUP_CHECK_EN, the third gives ok=0, found=1, index=0, count=2.
- List holds (5,7),(9,2),(3,3); SEARCH (3,3) -> done 5 cycles after grant, found=1, index=2. SEARCH (4,4) -> found=0, ok=1, no compare beyond entry 2.
- SEARCH on an empty list -> done 3 cycles after grant, found=0, ok=1.
- List (5,7),(9,2),(3,3); REMOVE idx=0 -> entry0=(3,3), count=2. REMOVE idx=5 -> ok=0, count unchanged.
- Both req high continuously -> grants alternate 01,10,01,10 across four operations; each grant is held until its done.
- Fill to DEPTH=400 -> full=1; a further INSERT gives ok=0 and count stays 400. Drop Reset_n mid-SCAN -> immediately grant=0, count=0, empty=1, no done pulse.
